// File: rtl/btn_conditioner_if.sv
// Signal bundle between the pushbutton conditioner and its surroundings:
// raw buttons and game_over in, command pulses and debug state out.
interface btn_conditioner_if;
    logic       btn_l_raw;
    logic       btn_r_raw;
    logic       btn_drop_raw;
    logic       game_over;
    logic       btn_l;
    logic       btn_r;
    logic       btn_drop;
    logic [2:0] held;
    logic [1:0] rpt_state;

    modport master (
        input  btn_l_raw, btn_r_raw, btn_drop_raw, game_over,
        output btn_l, btn_r, btn_drop, held, rpt_state
    );

    modport slave (
        output btn_l_raw, btn_r_raw, btn_drop_raw, game_over,
        input  btn_l, btn_r, btn_drop, held, rpt_state
    );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronizes and debounces three pushbuttons; L/R become pulses with auto-repeat,
// drop becomes a single pulse. Outputs are masked while game_over is high.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 30000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 25
) (
    input logic               clk,
    input logic               rst,
    btn_conditioner_if.master bus
);

    localparam logic [CNT_W-1:0] DbLast     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StRepeat = 2'd2,
        StLock   = 2'd3
    } rpt_state_e;

    // Bit order everywhere: [0]=l, [1]=r, [2]=drop.
    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       db_q;
    logic [2:0]       db_d;
    logic [2:0]       accept;
    logic [2:0]       rise;
    logic [CNT_W-1:0] cnt_q [3];

    rpt_state_e       state_q;
    logic             dir_r_q;
    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_last;
    logic             btn_l_q;
    logic             btn_r_q;
    logic             btn_drop_q;
    logic             lr_ok;
    logic             dir_fall;
    logic             opp_rise;

    assign raw = {bus.btn_drop_raw, bus.btn_r_raw, bus.btn_l_raw};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            accept[i] = (sync2_q[i] != db_q[i]) && (cnt_q[i] == DbLast);
            rise[i]   = accept[i] & sync2_q[i];
        end
        db_d = db_q ^ accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_q[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A drop pulse on the same edge wins; the L/R pulse is dropped but the FSM still advances.
    assign lr_ok    = ~rise[2] & ~bus.game_over;
    assign dir_fall = dir_r_q ? (accept[1] & ~sync2_q[1]) : (accept[0] & ~sync2_q[0]);
    assign opp_rise = dir_r_q ? rise[0] : rise[1];
    assign tmr_last = (state_q == StHold) ? DelayLast : PeriodLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dir_r_q    <= 1'b0;
            tmr_q      <= '0;
            btn_l_q    <= 1'b0;
            btn_r_q    <= 1'b0;
            btn_drop_q <= 1'b0;
        end else begin
            btn_l_q    <= 1'b0;
            btn_r_q    <= 1'b0;
            btn_drop_q <= rise[2] & ~bus.game_over;
            case (state_q)
                StIdle: begin
                    tmr_q <= '0;
                    if (rise[0] && !db_d[1]) begin
                        state_q <= StHold;
                        dir_r_q <= 1'b0;
                        btn_l_q <= lr_ok;
                    end else if (rise[1] && !db_d[0]) begin
                        state_q <= StHold;
                        dir_r_q <= 1'b1;
                        btn_r_q <= lr_ok;
                    end else if (rise[0] || rise[1]) begin
                        state_q <= StLock;
                    end
                end
                StHold, StRepeat: begin
                    if (dir_fall) begin
                        state_q <= StIdle;
                        tmr_q   <= '0;
                    end else if (opp_rise) begin
                        state_q <= StLock;
                        tmr_q   <= '0;
                    end else if (tmr_q == tmr_last) begin
                        state_q <= StRepeat;
                        tmr_q   <= '0;
                        btn_l_q <= lr_ok & ~dir_r_q;
                        btn_r_q <= lr_ok & dir_r_q;
                    end else begin
                        tmr_q <= tmr_q + CNT_W'(1);
                    end
                end
                StLock: begin
                    tmr_q <= '0;
                    if (!db_d[0] && !db_d[1]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.btn_l     = btn_l_q;
    assign bus.btn_r     = btn_r_q;
    assign bus.btn_drop  = btn_drop_q;
    assign bus.held      = db_q;
    assign bus.rpt_state = state_q;

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles (10 ms at 100 MHz) needed to accept a level change.
REQ-002 Parameter REPEAT_DELAY, default 30000000, is the number of cycles from the initial L/R pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the number of cycles between subsequent auto-repeat pulses.
REQ-004 Parameter CNT_W, default 25, is the counter width and SHALL hold every parameter value minus 1.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn_l_raw, btn_r_raw, btn_drop_raw  input  1 each  asynchronous raw pushbuttons, active high.
REQ-008 game_over  input  1  from the core; masks all pulse outputs while high.
REQ-009 btn_l, btn_r, btn_drop  output  1 each  registered single-cycle command pulses driving the core inputs of the same names.
REQ-010 held  output  3  debounced levels {drop, r, l}, registered.
REQ-011 rpt_state  output  2  current L/R repeat FSM state, for debug.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer. Its output sync_x equals raw_x delayed 2 edges.
REQ-013 Debounce (per button): stable register db_x and counter cnt_x.
- If sync_x == db_x, cnt_x <= 0.
- Else if cnt_x == DEBOUNCE_CYCLES-1, then db_x <= sync_x and cnt_x <= 0.
- Else cnt_x increments.
REQ-014 Debounce latency: raw_x is first sampled high at edge N and held. db_x SHALL rise at edge N+1+DEBOUNCE_CYCLES. Falling edges use identical timing.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave db_x unchanged and produce no pulse.
REQ-016 btn_drop SHALL be high for exactly one cycle, registered on the same edge at which db_drop rises. Drop SHALL never auto-repeat.
REQ-017 The L/R FSM SHALL have states IDLE=0, HOLD=1, REPEAT=2, LOCK=3, and a shared timer tmr.
- IDLE: on db_l rising with db_r low, pulse btn_l, clear tmr, go to HOLD (direction latched as L). The mirror case applies for R.
- IDLE: if db_l and db_r both rise on the same edge, emit no pulse and go to LOCK.
- HOLD: tmr increments each cycle. At tmr == REPEAT_DELAY-1, pulse the latched direction, clear tmr, go to REPEAT.
- REPEAT: tmr increments each cycle. At tmr == REPEAT_PERIOD-1, pulse, clear tmr, stay in REPEAT.
- HOLD or REPEAT: if the latched direction's db falls, go to IDLE with no pulse. If the opposite direction's db rises, go to LOCK with no pulse.
- LOCK: emit no L/R pulses. Go to IDLE when db_l and db_r are both low.
REQ-018 At most one of btn_l, btn_r, btn_drop SHALL be high in any cycle.
- If a drop pulse and an L/R pulse fall on the same edge, drop is emitted and the L/R pulse is discarded, not deferred.
- The FSM and timer advance as if the discarded L/R pulse had been emitted.
REQ-019 While game_over is high, all three pulse outputs SHALL be 0. Synchronizers, debounce and FSM SHALL keep running. Pulses suppressed this way are lost.
REQ-020 held SHALL equal {db_drop, db_r, db_l}.

Reset
REQ-021 On rst high at a clock edge, the following SHALL be cleared on that edge:
- synchronizer flops, db_x, cnt_x and tmr to 0;
- rpt_state to IDLE;
- btn_l, btn_r, btn_drop and held to 0.
REQ-022 Reset SHALL take priority over all other activity, including reset asserted mid-debounce or mid-repeat.
REQ-023 A button held through reset release SHALL be debounced afresh after release and SHALL produce one initial pulse, per REQ-014 timing counted from the first post-reset sampling edge.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
REQ-024 Scenario 1: btn_drop_raw high from edge N for 30 cycles -> btn_drop high only during the cycle following edge N+5; held[2] high from edge N+5; no further pulses.
REQ-025 Scenario 2: btn_l_raw high for 2 cycles, then low -> db_l unchanged, no btn_l pulse, held[0] stays 0.
REQ-026 Scenario 3: btn_l_raw held 40 cycles from edge N -> btn_l pulses at edges N+5, N+15, N+20, N+25, N+30, N+35, N+40; rpt_state goes 1 then 2. After release, rpt_state returns to 0 with no further pulse.
REQ-027 Scenario 4: btn_l_raw held, then btn_r_raw pressed 8 cycles later -> after btn_r debounces, rpt_state=3 and no btn_l/btn_r pulses. After both are released and debounced, rpt_state=0.
REQ-028 Scenario 5: btn_drop_raw pressed with game_over=1 -> no btn_drop pulse, held[2] rises normally. A new press after game_over falls -> one pulse.
REQ-029 Scenario 6: rst asserted for 1 cycle mid-REPEAT with btn_r_raw still held -> all outputs 0 on the next cycle. A fresh initial btn_r pulse occurs 5 edges after the first post-reset sampling edge, followed by repeat timing per Scenario 3.
